// File: rtl/instruction_fetch.sv
// Fetch stage between the ProgramCounter and decode.
// Launches one bus read per instruction from the current PC and holds the word
// for decode. It advances the PC only when decode accepts the word, and drops
// words that a redirect (flush) makes stale.
//
// Handshake rules, for both the bus side and the decode side:
//   - A source raises valid (busRequest / instrValid) and keeps its payload
//     (busAddress / instruction+instrPC) stable until the transfer completes.
//   - A transfer completes in any cycle where valid and ready
//     (busReady / instrReady) are both high.
//   - valid never depends combinationally on ready.
//   - Only one bus read is outstanding at a time.
module instruction_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic                  pcAdvance,
    output logic [ADDR_WIDTH-1:0] busAddress,
    output logic                  busRequest,
    input  logic                  busReady,
    input  logic [DATA_WIDTH-1:0] busData,
    output logic                  instrValid,
    input  logic                  instrReady,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instrPC,
    output logic                  misaligned,
    output logic [1:0]            fetchState
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        HOLD    = 2'd2,
        FAULT   = 2'd3
    } stateT;

    stateT                 state;
    stateT                 nextState;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic [DATA_WIDTH-1:0] instrReg;
    logic                  discard;
    logic                  pcAligned;

    assign pcAligned = (pc[1:0] == 2'b00);

    // State register; reset abandons any bus transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; flush always has priority over progress.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (flush) begin
                    nextState = IDLE;
                end else if (!pcAligned) begin
                    nextState = FAULT;
                end else begin
                    nextState = REQUEST;
                end
            end
            REQUEST: begin
                if (busReady) begin
                    nextState = (discard || flush) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (flush || instrReady) begin
                    nextState = IDLE;
                end
            end
            FAULT: begin
                if (flush) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: latch the fetch address at launch and capture the bus word.
    // The discard flag remembers a redirect seen while the read is still
    // outstanding, because a started bus read is never aborted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addrReg  <= '0;
            instrReg <= '0;
            discard  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush && pcAligned) begin
                        addrReg <= pc;
                    end
                end
                REQUEST: begin
                    if (busReady) begin
                        discard <= 1'b0;
                        if (!(discard || flush)) begin
                            instrReg <= busData;
                        end
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are decoded from the state. pcAdvance loses to flush so that
    // the PC is never written and counted in the same cycle.
    always_comb begin
        busRequest = (state == REQUEST);
        instrValid = (state == HOLD);
        misaligned = (state == FAULT);
        pcAdvance  = (state == HOLD) && instrReady && !flush;
    end

    assign busAddress  = addrReg;
    assign instrPC     = addrReg;
    assign instruction = instrReg;
    assign fetchState  = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch. It contains a ProgramCounter model and a bus
// responder with programmable wait states. Every word that should reach
// decode is queued when the bus returns it, and a separate monitor pops the
// queue when a new word appears at the decode interface.
module tb_instruction_fetch;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] pc;
    logic          flush = 1'b0;
    logic [AW-1:0] flushTarget = '0;
    logic          pcAdvance;
    logic [AW-1:0] busAddress;
    logic          busRequest;
    logic          busReady = 1'b0;
    logic [DW-1:0] busData = '0;
    logic          instrValid;
    logic          instrReady = 1'b0;
    logic [DW-1:0] instruction;
    logic [AW-1:0] instrPC;
    logic          misaligned;
    logic [1:0]    fetchState;

    int            nChecks = 0;
    int            nFail = 0;
    int            cycleCnt = 0;
    int            waitCfg = 0;
    logic          useFixed = 1'b0;
    logic [DW-1:0] fixedData = '0;
    logic [63:0]   exp_q[$];

    instruction_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .flush(flush),
        .pcAdvance(pcAdvance),
        .busAddress(busAddress),
        .busRequest(busRequest),
        .busReady(busReady),
        .busData(busData),
        .instrValid(instrValid),
        .instrReady(instrReady),
        .instruction(instruction),
        .instrPC(instrPC),
        .misaligned(misaligned),
        .fetchState(fetchState)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // ProgramCounter: a write on flush wins, otherwise count by 4 on pcAdvance.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (flush) begin
            pc <= flushTarget;
        end else if (pcAdvance) begin
            pc <= pc + 32'd4;
        end
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void checkAllZero(input string name);
        check({name, "_pcAdvance"}, {63'd0, pcAdvance}, 64'd0);
        check({name, "_busAddress"}, {32'd0, busAddress}, 64'd0);
        check({name, "_busRequest"}, {63'd0, busRequest}, 64'd0);
        check({name, "_instrValid"}, {63'd0, instrValid}, 64'd0);
        check({name, "_instruction"}, {32'd0, instruction}, 64'd0);
        check({name, "_instrPC"}, {32'd0, instrPC}, 64'd0);
        check({name, "_misaligned"}, {63'd0, misaligned}, 64'd0);
    endfunction

    // Bus responder: answers each read after waitCfg wait cycles (random 0..3
    // when waitCfg < 0). A returned word is expected at decode only when no
    // flush was seen at any point during its request.
    initial begin : responder
        logic          active;
        logic          flushed;
        int            left;
        logic [AW-1:0] reqAddr;
        active  = 1'b0;
        flushed = 1'b0;
        left    = 0;
        reqAddr = '0;
        forever begin
            @(posedge clk);
            #2;
            busReady = 1'b0;
            if (!reset || !busRequest) begin
                active = 1'b0;
                continue;
            end
            if (!active) begin
                active  = 1'b1;
                flushed = 1'b0;
                reqAddr = busAddress;
                left    = (waitCfg < 0) ? int'($urandom_range(0, 3)) : waitCfg;
                check("fetch_addr", {32'd0, busAddress}, {32'd0, pc});
            end else begin
                check("addr_hold", {32'd0, busAddress}, {32'd0, reqAddr});
            end
            flushed = flushed | flush;
            if (left == 0) begin
                busReady = 1'b1;
                busData  = useFixed ? fixedData : $urandom;
                if (!flushed) exp_q.push_back({reqAddr, busData});
                active = 1'b0;
            end else begin
                left--;
            end
        end
    end

    // Monitor: compares each new decode word with the queue, checks that a
    // held word stays stable, and checks the advance and fault rules.
    initial begin : monitor
        logic          prevValid;
        logic [DW-1:0] heldInstr;
        logic [AW-1:0] heldPC;
        logic [63:0]   e;
        prevValid = 1'b0;
        heldInstr = '0;
        heldPC    = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prevValid = 1'b0;
                continue;
            end
            if (instrValid && !prevValid) begin
                if (exp_q.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL unexpected_word: got instrPC=%0h word=%0h, required no word", instrPC, instruction);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", {32'd0, instrPC}, {32'd0, e[63:32]});
                    check("instr_word", {32'd0, instruction}, {32'd0, e[31:0]});
                end
                heldInstr = instruction;
                heldPC    = instrPC;
            end else if (instrValid) begin
                check("hold_word", {32'd0, instruction}, {32'd0, heldInstr});
                check("hold_pc", {32'd0, instrPC}, {32'd0, heldPC});
            end
            check("pc_advance", {63'd0, pcAdvance}, {63'd0, instrValid & instrReady & ~flush});
            if (misaligned) begin
                check("fault_quiet", {62'd0, busRequest, instrValid}, 64'd0);
                check("fault_pc", {63'd0, pc[1:0] != 2'b00}, 64'd1);
            end
            prevValid = instrValid;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks; stimulus changes 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doFlush(input logic [AW-1:0] target);
        flushTarget = target;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic waitReq(input logic [AW-1:0] addr);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busRequest && busAddress == addr) begin
                found = 1'b1;
                break;
            end
        end
        nChecks++;
        if (!found) begin
            nFail++;
            $display("FAIL req_timeout: got no request at %0h (state=%0d), required one", addr, fetchState);
        end
    endtask

    task automatic waitValid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instrValid || misaligned) begin
                found = 1'b1;
                break;
            end
        end
        nChecks++;
        if (!found) begin
            nFail++;
            $display("FAIL valid_timeout: got no word (state=%0d), required one", fetchState);
        end
    endtask

    task automatic waitAdvance();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pcAdvance) begin
                found = 1'b1;
                break;
            end
        end
        nChecks++;
        if (!found) begin
            nFail++;
            $display("FAIL advance_timeout: got no pcAdvance (state=%0d), required one", fetchState);
        end
    endtask

    task automatic park();
        instrReady = 1'b0;
        waitValid();
        step();
    endtask

    // Directed scenarios, then a randomized run, then a drain.
    initial begin : stimulus
        int          n;
        int          nv;
        int          c1;
        bit          found;
        logic [31:0] r;

        // Reset state, then reset in the middle of a bus read.
        #1;
        checkAllZero("reset");
        waitCfg = 5;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        waitReq(32'h0);
        #1 reset = 1'b0;
        #1 checkAllZero("reset_mid");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        waitReq(32'h0);

        // Zero-wait fetch at 0x100, accepted at once: 3 cycles per instruction.
        waitCfg   = 0;
        useFixed  = 1'b1;
        fixedData = 32'h0050_0093;
        step();
        park();
        instrReady = 1'b1;
        doFlush(32'h100);
        waitAdvance();
        check("t2_pc", {32'd0, instrPC}, 64'h100);
        check("t2_word", {32'd0, instruction}, 64'h0050_0093);
        c1 = cycleCnt;
        waitAdvance();
        check("t2_period", 64'(cycleCnt - c1), 64'd3);
        check("t2_next_pc", {32'd0, instrPC}, 64'h104);

        // Three bus wait cycles at 0x20.
        step();
        park();
        waitCfg   = 3;
        fixedData = 32'hCAFE_0123;
        doFlush(32'h20);
        waitReq(32'h20);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busRequest && busAddress == 32'h20) n++;
            else break;
        end
        check("t3_req_cycles", 64'(n), 64'd4);
        check("t3_valid", {63'd0, instrValid}, 64'd1);
        check("t3_word", {32'd0, instruction}, 64'hCAFE_0123);

        // Flush in the second wait cycle at 0x40, redirect to 0x80.
        step();
        useFixed = 1'b0;
        doFlush(32'h40);
        waitReq(32'h40);
        step();
        doFlush(32'h80);
        nv = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instrValid) nv++;
            if (busRequest && busAddress == 32'h80) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_req_80", {63'd0, found}, 64'd1);
        check("t4_no_valid", 64'(nv), 64'd0);

        // Hold for 5 cycles without ready, then flush together with ready.
        waitCfg = 0;
        waitValid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_no_adv", {63'd0, pcAdvance}, 64'd0);
            check("t5_pc", {32'd0, instrPC}, 64'h80);
        end
        step();
        flushTarget = 32'h200;
        flush = 1'b1;
        instrReady = 1'b1;
        @(negedge clk);
        check("t5_flush_wins", {63'd0, pcAdvance}, 64'd0);
        step();
        flush = 1'b0;
        instrReady = 1'b0;
        waitReq(32'h200);

        // Misaligned PC faults until a redirect to an aligned address.
        park();
        doFlush(32'h102);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_misaligned", {63'd0, misaligned}, 64'd1);
            check("t6_no_req", {63'd0, busRequest}, 64'd0);
        end
        step();
        doFlush(32'h104);
        @(negedge clk);
        check("t6_cleared", {63'd0, misaligned}, 64'd0);
        waitReq(32'h104);

        // The top of the address space: the PC wraps to 0 after this word.
        step();
        park();
        instrReady = 1'b1;
        doFlush(32'hFFFF_FFFC);
        waitReq(32'hFFFF_FFFC);
        waitReq(32'h0);

        // Randomized ready, wait states and redirects.
        waitCfg = -1;
        step();
        for (int i = 0; i < 600; i++) begin
            instrReady = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) begin
                r = $urandom;
                flushTarget = ($urandom_range(0, 3) == 0) ? r : {r[31:2], 2'b00};
                flush = 1'b1;
            end else begin
                flush = 1'b0;
            end
            step();
        end
        flush = 1'b0;

        // Park in a fault so nothing more is fetched, then confirm every
        // expected word was seen.
        step();
        doFlush(32'h2);
        repeat (12) step();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_fault", {63'd0, misaligned}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
